// File: rtl/clb_cfg_loader_if.sv
// Handshake and configuration bus between a bitstream source and the CLB
// configuration loader.
interface clb_cfg_loader_if #(
  parameter int unsigned CfgW = 33,
  parameter int unsigned NClb = 2
);
  logic                   cfg_start;
  logic                   bs_in;
  logic                   bs_valid;
  logic                   bs_ready;
  logic [NClb*CfgW-1:0]   cfg_out;
  logic                   cfg_done;
  logic                   cfg_err;

  // Bitstream source side
  modport master (
    output cfg_start, bs_in, bs_valid,
    input  bs_ready, cfg_out, cfg_done, cfg_err
  );

  // Loader side
  modport slave (
    input  cfg_start, bs_in, bs_valid,
    output bs_ready, cfg_out, cfg_done, cfg_err
  );
endinterface

// File: rtl/clb_cfg_loader.sv
// Serial configuration loader feeding the CLB slices. Hunts for a sync word,
// shifts NClb*CfgW payload bits into a staging register, checks an even-parity
// bit and only then commits the whole word to the parallel cfg bus, so CLBs
// never observe a partially loaded configuration.
module clb_cfg_loader #(
  parameter int unsigned      CfgW     = 33,
  parameter int unsigned      NClb     = 2,
  parameter int unsigned      SyncW    = 8,
  parameter logic [SyncW-1:0] SyncWord = 8'hA5
) (
  input logic             f_clk,
  input logic             rst_n,
  clb_cfg_loader_if.slave cfg_if
);

  localparam int unsigned     TotalW  = NClb * CfgW;
  localparam int unsigned     CntW    = $clog2(TotalW + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(TotalW - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StLoad,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e            state_q;
  logic [SyncW-1:0]  sync_q;
  logic [TotalW-1:0] stage_q;
  logic [TotalW-1:0] cfg_q;
  logic [CntW-1:0]   cnt_q;
  logic              par_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic              bit_in;
  logic [SyncW-1:0]  sync_shift;

  // Ready is a pure decode of the registered state.
  assign cfg_if.bs_ready = (state_q == StSync) || (state_q == StLoad) || (state_q == StCheck);
  assign accept          = cfg_if.bs_valid & cfg_if.bs_ready;
  // Gate the data bit so an undriven bs_in while not accepting never reaches state.
  assign bit_in          = accept ? cfg_if.bs_in : 1'b0;
  assign sync_shift      = (sync_q << 1) | SyncW'(bit_in);

  assign cfg_if.cfg_out  = cfg_q;
  assign cfg_if.cfg_done = done_q;
  assign cfg_if.cfg_err  = err_q;

  // Loader FSM with all datapath registers and registered status outputs.
  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sync_q  <= '0;
      stage_q <= '0;
      cfg_q   <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cfg_if.cfg_start) begin
            sync_q  <= '0;
            state_q <= StSync;
          end
        end
        StSync: begin
          if (accept) begin
            sync_q <= sync_shift;
            if (sync_shift == SyncWord) begin
              cnt_q   <= '0;
              par_q   <= 1'b0;
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (accept) begin
            // First payload bit ends up at the MSB of the committed word.
            stage_q <= (stage_q << 1) | TotalW'(bit_in);
            par_q   <= par_q ^ bit_in;
            cnt_q   <= cnt_q + CntW'(1);
            if (cnt_q == LastIdx) begin
              state_q <= StCheck;
            end
          end
        end
        StCheck: begin
          if (accept) begin
            if (bit_in == par_q) begin
              cfg_q   <= stage_q;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
              state_q <= StDone;
            end else begin
              done_q  <= 1'b0;
              err_q   <= 1'b1;
              state_q <= StError;
            end
          end
        end
        StDone, StError: begin
          // cfg_q keeps the last good load across a restart.
          if (cfg_if.cfg_start) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sync_q  <= '0;
            state_q <= StSync;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
